// File: rtl/seq_word_adder_pkg.sv
// seq_word_adder_pkg: shared FSM states, slice width and index-width helper
package seq_word_adder_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/seq_word_adder_rca8bit.sv
// rca8bit: 8-bit ripple-carry adder with a tap on the carry out of the low nibble
module rca8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       c4,
  output logic       cout
);
  logic [8:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign c4   = c[4];
  assign cout = c[8];
endmodule

// File: rtl/seq_word_adder.sv
// seq_word_adder: wide add computed one byte per clock through a single rca8bit
module seq_word_adder
  import seq_word_adder_pkg::*;
#(
  parameter int NBYTES = 4,
  localparam int W = BYTE_W * NBYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         busy
);
  localparam int IW = idx_w(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  state_t          state, state_nxt;
  logic [IW-1:0]   idx;
  logic [W-1:0]    a_q, b_q, sum_q, sum_nxt;
  logic            carry_q;
  logic [7:0]      s;
  logic            cout;
  logic            last;

  assign last = (idx == LAST);

  rca8bit u_slice (
    .a    (a_q[BYTE_W*idx +: BYTE_W]),
    .b    (b_q[BYTE_W*idx +: BYTE_W]),
    .cin  (carry_q),
    .s    (s),
    .c4   (),
    .cout (cout)
  );

  // Current slice result merged into the partial sum
  always_comb begin
    sum_nxt = sum_q;
    sum_nxt[BYTE_W*idx +: BYTE_W] = s;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs; no bypass from DONE straight to a new accept
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-slice accumulation and final result load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      idx      <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_q     <= in_a;
      b_q     <= in_b;
      carry_q <= in_cin;
      idx     <= '0;
    end else if (state == RUN) begin
      sum_q   <= sum_nxt;
      carry_q <= cout;
      idx     <= idx + 1'b1;
      if (last) begin
        out_sum  <= sum_nxt;
        out_cout <= cout;
        out_ovf  <= cout ^ (a_q[W-1] ^ b_q[W-1] ^ s[7]);
      end
    end
  end
endmodule

// File: doc/seq_word_adder.md
Name: seq_word_adder

Overview:
- Multi-cycle wide-word adder that drives the existing 8-bit ripple-carry adder (rca8bit) one byte slice per clock, least significant byte first.
- Registers the carry between slices and assembles the full sum.
- Sits between an operand producer (valid/ready) and a result consumer (valid/ready).
- Trades latency for area: one 8-bit adder serves an arbitrarily wide datapath.

Parameters:
- NBYTES, 4, number of 8-bit slices; datapath width W = 8*NBYTES; legal range 1..16.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept operands.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_cin  input  1  carry-in to the least significant slice.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  W  A+B+cin modulo 2^W.
- out_cout  output  1  carry out of the top slice.
- out_ovf  output  1  two's-complement overflow of the W-bit add.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; out_sum=0; out_cout=0; out_ovf=0; busy=0; all internal operand, carry and index registers = 0. An operation in progress is discarded with no partial output.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch in_a, in_b, in_cin; idx=0; go to RUN.
- RUN:
  - in_ready=0. in_valid is ignored and operands are not sampled.
  - Each cycle, adder inputs are A=a_reg[8*idx+:8], B=b_reg[8*idx+:8], C=carry_reg.
  - At the edge: sum_reg[8*idx+:8]<=S; carry_reg<=Cout; idx<=idx+1.
  - rca8bit's intermediate nibble carry output is left unconnected.
  - When idx==NBYTES-1 at the edge: go to DONE. In the same edge, load out_sum, out_cout=Cout, and out_ovf=Cout^(a[W-1]^b[W-1]^S[7]) (carry into MSB xor carry out).
- DONE:
  - out_valid=1. out_sum, out_cout and out_ovf are held stable while out_valid&&!out_ready.
  - On out_ready at an edge: go to IDLE; out_valid=0. Data outputs keep their last value.
  - No same-cycle bypass: in_ready stays 0 during DONE, even when out_ready=1.
- Timing:
  - Latency: operands accepted at edge k, so out_valid is high after edge k+NBYTES.
  - Minimum initiation interval is NBYTES+2 cycles.
- Width rules:
  - All arithmetic is unsigned modulo 2^W; carry propagates only through carry_reg.
  - idx width is clog2(NBYTES), minimum 1.
- NBYTES=1 boundary: RUN lasts one cycle.
- Wrap-around: 0xFF..FF+1 gives sum 0 and cout=1.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE, RUN, DONE), 2-bit encoding.
  - BYTE_W=8 constant.
  - A function computing the index width from NBYTES.
- Natural sub-module: the existing rca8bit, instantiated once as the slice adder.
- No new sub-module is needed. The FSM, index counter and sum assembly stay in seq_word_adder.

Test Plan:
- NBYTES=4, a=0x000000FF, b=0x00000001, cin=0, out_ready=1 -> out_sum=0x00000100, cout=0, ovf=0; out_valid rises exactly 4 edges after the accept edge.
- a=0xFFFFFFFF, b=0x00000000, cin=1 -> out_sum=0x00000000, cout=1, ovf=0 (carry ripples through all four slices).
- a=0x7FFFFFFF, b=0x00000001, cin=0 -> out_sum=0x80000000, cout=0, ovf=1. Then a=0x80000000, b=0x80000000 -> sum=0, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, and toggle in_valid with new operands during RUN and DONE -> outputs stay stable, in_ready=0 throughout, the new operands are accepted only after return to IDLE, and no result is lost or duplicated.
- Reset mid-operation: assert rst_n=0 asynchronously during RUN at idx=2 -> all outputs go to reset values immediately with no clock edge needed. After release, a fresh add of 0x12345678+0x11111111 gives 0x23456789.
- Back-to-back: stream 3 operand sets with in_valid and out_ready held high -> accepts are NBYTES+2 cycles apart, and results arrive in order with correct sums.
